mux8_rr_sched: RTL

- Round-robin scheduler that shares one 8:1 single-bit mux path among 8 requesters.
- Each requester i owns mux input i. The block arbitrates req[7:0], registers the winner's index onto the mux select, and holds the grant until the owner releases.
- Sits directly in front of the 8:1 mux. Its sel output drives the mux select and its y output carries the selected bit.

---
 rtl/mux8_rr_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin scheduler in front of an 8:1 single-bit mux.
// Arbitrates req[7:0], registers the winner onto grant/sel and holds the
// grant until the owner drops its request; release hands the mux over
// back-to-back to the next requester in rotation.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after MAX_HOLD cycles).
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   req      request vector, req[i] = requester i wants the mux
//   I        mux data inputs, I[i] driven by requester i
//   grant    registered one-hot grant, zero when idle
//   sel      registered mux select (index of granted requester)
//   busy     registered, high while a grant is active
//   y        combinational mux output, I[sel] when busy else 0
//   timeout  registered one-cycle pulse on forced release (0 without macro)
module mux8_rr_sched #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] I,
   output logic [7:0] grant,
   output logic [2:0] sel,
   output logic       busy,
   output logic       y,
   output logic       timeout
);

   localparam int unsigned N  = 8;
   localparam int unsigned SW = 3;
   localparam int unsigned CW = 8;

   // Elaboration-time guard on the hold limit
   if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
      $error("mux8_rr_sched: MAX_HOLD must be in 2..255");
   end

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic            busy_q, busy_d;
   logic            timeout_q, timeout_d;
   logic [SW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [SW:0]     pick_idle_c;
   logic [SW:0]     pick_rel_c;
   logic            force_rel_c;

   // Rotating priority search starting after p; {found, index}.
   // With excl set, p itself is skipped (the releasing owner).
   function automatic logic [SW:0] rr_pick(input logic [N-1:0] r,
                                           input logic [SW-1:0] p,
                                           input logic excl);
      logic [SW:0]   res;
      logic [SW-1:0] idx;
      res = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = p + SW'(i);
         if (!res[SW] && r[idx] && !(excl && (idx == p))) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   assign pick_idle_c = rr_pick(req, ptr_q, 1'b0);
   assign pick_rel_c  = rr_pick(req, sel_q, 1'b1);

`ifdef ARB_TIMEOUT_EN
   // Owner still requesting but has used up its hold budget
   assign force_rel_c = req[sel_q] && (cnt_q == CW'(MAX_HOLD));
`else
   assign force_rel_c = 1'b0;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      sel_d     = sel_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_idle_c[SW]) begin
               state_d = ST_GRANT;
               grant_d = N'(1) << pick_idle_c[SW-1:0];
               sel_d   = pick_idle_c[SW-1:0];
               busy_d  = 1'b1;
               cnt_d   = CW'(1);
            end
         end
         ST_GRANT: begin
            if (req[sel_q] && !force_rel_c) begin
               if (cnt_q != {CW{1'b1}}) begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               // Release (voluntary or forced): rotate pointer past the owner
               ptr_d     = sel_q;
               timeout_d = force_rel_c;
               if (pick_rel_c[SW]) begin
                  grant_d = N'(1) << pick_rel_c[SW-1:0];
                  sel_d   = pick_rel_c[SW-1:0];
                  cnt_d   = CW'(1);
               end else begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  busy_d  = 1'b0;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         sel_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         ptr_q     <= SW'(N - 1);
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign grant   = grant_q;
   assign sel     = sel_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;
   assign y       = busy_q ? I[sel_q] : 1'b0;

endmodule
